rst_seq_ctrl: RTL
=================

# rst_seq_ctrl

Reset-sequence initiator for the polynomial evaluation accelerator. On a request it walks a bank of downstream reset FSMs one at a time. For each channel it pulses that channel's `start_rst` for one cycle and waits for the matching one-cycle `done_rst`, with a per-attempt timeout and a bounded retry count. It reports overall completion or the index of the failing channel to the top-level controller.

## Interface
- `N_CH`, default 3: number of downstream reset channels (≥2).
- `TIMEOUT`, default 8: maximum cycles spent waiting for `done_rst` per attempt (≥3).
- `MAX_RETRY`, default 1: re-issues allowed per channel after a timeout, so total attempts are `MAX_RETRY+1`.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, 1: start a full reset sequence; sampled only in IDLE, DONE or FAIL.
- `start_rst`, output, N_CH: one-hot, registered; bit i pulses high one cycle to start channel i.
- `done_rst`, input, N_CH: completion pulses from the downstream FSMs; bit i is one cycle wide.
- `busy`, output, 1: sequence in progress.
- `ready`, output, 1: all channels completed; held until the next `req` or `rst`.
- `fail`, output, 1: a channel exhausted its retries; held until the next `req` or `rst`.
- `fail_ch`, output, $clog2(N_CH): index of the failing channel; valid while `fail`=1, otherwise 0.

## Operation
- Internal registers: channel index `ch`, retry counter `retry`, wait timer `tmr`. `tmr` is wide enough to hold TIMEOUT-1.
- States and actions:
  - IDLE: all outputs 0. `req`=1 → ISSUE, with `ch`=0 and `retry`=0.
  - ISSUE: `start_rst[ch]`=1 and `busy`=1, for exactly one cycle. `tmr`←0. Next state is always WAIT.
  - WAIT: `busy`=1, `start_rst`=0. Priority order:
    - `done_rst[ch]`=1 and `ch`=N_CH-1 → DONE.
    - `done_rst[ch]`=1 otherwise → ISSUE, with `ch`+1 and `retry`←0.
    - `tmr`=TIMEOUT-1 and `retry`<MAX_RETRY → ISSUE, with `retry`+1 and the same `ch`.
    - `tmr`=TIMEOUT-1 and `retry`=MAX_RETRY → FAIL, with `fail_ch`←`ch`.
    - Otherwise stay in WAIT, with `tmr`+1.
  - DONE: `ready`=1, `busy`=0. `req`=1 → ISSUE with `ch`=0, `retry`=0, and `ready` cleared.
  - FAIL: `fail`=1, `busy`=0, `fail_ch` held. `req`=1 → ISSUE with `ch`=0, `retry`=0, and `fail`/`fail_ch` cleared.
- Boundary rules:
  - `done_rst[ch]` in the same cycle as the timeout is treated as success; done wins.
  - `done_rst` bits other than `ch` are ignored in every state.
  - Any `done_rst` outside WAIT is ignored.
  - `req` during ISSUE or WAIT is ignored; there is no restart mid-sequence.
  - `req` held high across DONE or FAIL restarts the sequence once per entry into that state.
  - `start_rst` is never multi-hot and never high for two consecutive cycles.

## Timing
- Reset values: state IDLE; `start_rst`=0, `busy`=0, `ready`=0, `fail`=0, `fail_ch`=0; `ch`, `retry`, `tmr` all 0.
- Assertion of `rst` forces these values immediately, without waiting for a clock edge, including mid-sequence.
- After `rst` deasserts, the block is in IDLE and accepts `req` from the next rising edge.
- All outputs are registered or decoded from registered state only; there is no combinational path from an input to an output.
- `req` high in cycle 0 puts `start_rst[0]` high in cycle 1.
- Against the standard 3-state downstream reset FSM:
  - `done_rst[i]` arrives two cycles after `start_rst[i]`.
  - Each channel therefore costs 3 cycles: ISSUE, WAIT, WAIT.
- Successful-sequence latency: `ready` rises 3·N_CH+1 cycles after the `req` cycle, i.e. cycle 10 for N_CH=3.
- Each timed-out attempt costs 1+TIMEOUT cycles.

## Test plan
- Reset, then `req`=0 for 10 cycles → all outputs stay 0 and `start_rst` never pulses.
- Default parameters, 3-state FSM model on each channel, `req` pulse in cycle 0:
  - `start_rst` = 001, 010, 100 in cycles 1, 4 and 7.
  - `busy`=1 in cycles 1–9.
  - `ready`=1 from cycle 10, held 20 cycles.
- Channel 1 never responds:
  - `start_rst[1]` pulses in cycles 4 and 13.
  - `fail`=1 and `fail_ch`=1 from cycle 22.
  - `busy`=0 from cycle 22.
  - `start_rst[2]` never pulses.
- Channel 0 responds only to its second attempt:
  - Retry pulse in cycle 10; done in cycle 12.
  - `start_rst[1]` in cycle 13.
  - `ready` in cycle 19.
- Corner cases:
  - Stray `done_rst[2]` while waiting on channel 0 → ignored.
  - `done_rst[ch]` exactly at `tmr`=TIMEOUT-1 → advances to the next channel with no retry.
  - `req` pulsed while busy → no restart.
- Async reset mid-operation and restart:
  - Assert `rst` between clock edges in WAIT of channel 1 → outputs 0 immediately.
  - Release `rst` and issue `req` → a full sequence restarts at channel 0.
  - Then issue `req` from FAIL → `fail` clears and `start_rst[0]` pulses the next cycle.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// Reset-sequence initiator: walks N_CH downstream reset FSMs in order, pulsing start_rst and
// waiting for done_rst with a per-attempt timeout and bounded retries.
module rst_seq_ctrl #(
  parameter int unsigned N_CH      = 3,
  parameter int unsigned TIMEOUT   = 8,
  parameter int unsigned MAX_RETRY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic [N_CH-1:0]         done_rst,
  output logic [N_CH-1:0]         start_rst,
  output logic                    busy,
  output logic                    ready,
  output logic                    fail,
  output logic [$clog2(N_CH)-1:0] fail_ch
);

  localparam int unsigned ChW  = $clog2(N_CH);
  localparam int unsigned TmrW = $clog2(TIMEOUT);
  localparam int unsigned RtyW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [ChW-1:0]  LastCh  = ChW'(N_CH - 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);
  localparam logic [RtyW-1:0] RtyMax  = RtyW'(MAX_RETRY);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StFail} state_e;

  state_e          state_q, state_d;
  logic [ChW-1:0]  ch_q, ch_d;
  logic [RtyW-1:0] retry_q, retry_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [N_CH-1:0] start_d;
  logic [ChW-1:0]  fail_ch_d;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    retry_d = retry_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      StIdle, StDone, StFail: begin
        if (req) begin
          state_d = StIssue;
          ch_d    = '0;
          retry_d = '0;
        end
      end
      StIssue: begin
        state_d = StWait;
        tmr_d   = '0;
      end
      StWait: begin
        // Completion is checked before the timeout so a done on the last wait cycle wins.
        if (done_rst[ch_q]) begin
          if (ch_q == LastCh) begin
            state_d = StDone;
          end else begin
            state_d = StIssue;
            ch_d    = ch_q + ChW'(1);
            retry_d = '0;
          end
        end else if (tmr_q == TmrLast) begin
          if (retry_q < RtyMax) begin
            state_d = StIssue;
            retry_d = retry_q + RtyW'(1);
          end else begin
            state_d = StFail;
          end
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    start_d = '0;
    if (state_d == StIssue) begin
      start_d[ch_d] = 1'b1;
    end
    fail_ch_d = (state_d == StFail) ? ch_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      retry_q   <= '0;
      tmr_q     <= '0;
      start_rst <= '0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
      fail_ch   <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      retry_q   <= retry_d;
      tmr_q     <= tmr_d;
      start_rst <= start_d;
      busy      <= (state_d == StIssue) || (state_d == StWait);
      ready     <= (state_d == StDone);
      fail      <= (state_d == StFail);
      fail_ch   <= fail_ch_d;
    end
  end

endmodule
